// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} arb_state_e;
   typedef enum logic {SRC_IF = 1'b0, SRC_D = 1'b1} arb_src_e;

   localparam logic [2:0] FUNCT3_WORD = 3'b010;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_grant_sel.sv
// Combinational grant decision: load/store wins unless fetch has lost STARVE_MAX times in a row.
module mem_arb_grant_sel
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int STARVE_W   = 3
)(
   input  logic                if_valid,
   input  logic                d_valid,
   input  logic [STARVE_W-1:0] starve_cnt,
   output logic                grant_en,
   output arb_src_e            grant_src
);

   logic if_starved;

   always_comb begin
      if_starved = if_valid && (starve_cnt == STARVE_W'(STARVE_MAX));
      grant_en   = if_valid || d_valid;
      grant_src  = (d_valid && !if_starved) ? SRC_D : SRC_IF;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a fixed-latency access sequencer.
// Optional wait-cycle counters are built when MEM_ARB_PERF_EN is defined.
//
// state  | meaning
// IDLE   | port free; grant offered to the winning requester
// ACCESS | mem_en high for MEM_LAT cycles; read data sampled on the last one
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_funct3,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
`ifdef MEM_ARB_PERF_EN
   output logic [31:0]       perf_if_wait,
   output logic [31:0]       perf_d_wait,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_funct3,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int LAT_W    = cnt_w(MEM_LAT - 1);
   localparam int STARVE_W = cnt_w(STARVE_MAX);

   arb_state_e          state_q, state_d;
   logic [LAT_W-1:0]    lat_q;
   logic [STARVE_W-1:0] starve_q;
   arb_src_e            src_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          funct3_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                grant_en;
   arb_src_e            grant_src;
   logic                accept;
   logic                lat_done;

   mem_arb_grant_sel #(
      .STARVE_MAX (STARVE_MAX),
      .STARVE_W   (STARVE_W)
   ) u_grant_sel (
      .if_valid   (if_req_valid),
      .d_valid    (d_req_valid),
      .starve_cnt (starve_q),
      .grant_en   (grant_en),
      .grant_src  (grant_src)
   );

   always_comb begin
      state_d      = state_q;
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      accept       = 1'b0;
      lat_done     = (lat_q == '0);
      case (state_q)
         IDLE: begin
            if_req_ready = grant_en && (grant_src == SRC_IF);
            d_req_ready  = grant_en && (grant_src == SRC_D);
            accept       = grant_en;
            if (grant_en) state_d = ACCESS;
         end
         ACCESS: begin
            if (lat_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latched fields are only visible while the access runs, keeping the port quiet in IDLE.
   assign mem_en     = (state_q == ACCESS);
   assign mem_we     = mem_en && we_q;
   assign mem_addr   = mem_en ? addr_q   : '0;
   assign mem_funct3 = mem_en ? funct3_q : '0;
   assign mem_wdata  = mem_en ? wdata_q  : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lat_q        <= '0;
         starve_q     <= '0;
         src_q        <= SRC_IF;
         we_q         <= 1'b0;
         addr_q       <= '0;
         funct3_q     <= '0;
         wdata_q      <= '0;
         if_rsp_valid <= 1'b0;
         d_rsp_valid  <= 1'b0;
         if_rsp_data  <= '0;
         d_rsp_data   <= '0;
      end else begin
         state_q      <= state_d;
         if_rsp_valid <= 1'b0;
         d_rsp_valid  <= 1'b0;
         if (accept) begin
            src_q <= grant_src;
            lat_q <= LAT_W'(MEM_LAT - 1);
            if (grant_src == SRC_D) begin
               we_q     <= d_we;
               addr_q   <= d_addr;
               funct3_q <= d_funct3;
               wdata_q  <= d_wdata;
            end else begin
               we_q     <= 1'b0;
               addr_q   <= if_addr;
               funct3_q <= FUNCT3_WORD;
               wdata_q  <= '0;
            end
         end else if (state_q == ACCESS) begin
            if (lat_done) begin
               if (src_q == SRC_IF) begin
                  if_rsp_valid <= 1'b1;
                  if_rsp_data  <= mem_rdata;
               end else begin
                  d_rsp_valid <= 1'b1;
                  if (!we_q) d_rsp_data <= mem_rdata;
               end
            end else begin
               lat_q <= lat_q - 1'b1;
            end
         end
         if (if_req_ready) begin
            starve_q <= '0;
         end else if (d_req_ready && if_req_valid && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_q <= starve_q + 1'b1;
         end
      end
   end

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_if_wait <= '0;
         perf_d_wait  <= '0;
      end else begin
         if (if_req_valid && !if_req_ready) perf_if_wait <= perf_if_wait + 32'd1;
         if (d_req_valid && !d_req_ready)   perf_d_wait  <= perf_d_wait + 32'd1;
      end
   end
`endif

endmodule
